// File: rtl/term_loopback_matrix_cfg.sv
// Edge-tile termination matrix. Each channel turns END wires back into BEG wires.
// Per-channel modes are loaded through a length-checked serial chain.
module term_loopback_matrix_cfg #(
    parameter int NUM_CH   = 5,
    parameter int CH_W     = 16,
    parameter int CFG_BITS = 3*NUM_CH+1,
    parameter int CNT_W    = 8
) (
    input  logic                     UserCLK,
    input  logic                     reset,
    input  logic [NUM_CH*CH_W-1:0]   END_I,
    output logic [NUM_CH*CH_W-1:0]   BEG_O,
    output logic                     Co0,
    input  logic                     cfg_shift_en,
    input  logic                     cfg_in,
    input  logic                     cfg_commit,
    output logic                     cfg_out,
    output logic                     cfg_err,
    output logic [CFG_BITS-1:0]      cfg_active
);

    localparam logic [CNT_W-1:0] CFG_LEN = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0]    shreg;
    logic [CFG_BITS-1:0]    act;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_CH*CH_W-1:0] pipe;
    logic [NUM_CH*CH_W-1:0] rev_all;
    logic                   err_q;

    // Bit-reverse each channel group independently.
    always_comb begin
        rev_all = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < CH_W; i++) begin
                rev_all[c*CH_W + i] = END_I[c*CH_W + CH_W-1-i];
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            shreg <= '0;
            act   <= '0;
            cnt   <= '0;
            pipe  <= '0;
            err_q <= 1'b0;
        end else begin
            // Always loaded so a switch into registered mode sees current data.
            pipe <= rev_all;
            if (cfg_shift_en) begin
                shreg <= {shreg[CFG_BITS-2:0], cfg_in};
            end
            if (cfg_commit) begin
                if (cnt == CFG_LEN) begin
                    act   <= shreg;
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
                // A shift coinciding with commit opens the next window.
                cnt <= cfg_shift_en ? CNT_W'(1) : '0;
            end else if (cfg_shift_en && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [1:0]      mode;
            logic            inv;
            logic [CH_W-1:0] beg_c;

            assign mode = act[3*c +: 2];
            assign inv  = act[3*c + 2];

            always_comb begin
                beg_c = rev_all[c*CH_W +: CH_W] ^ {CH_W{inv}};
                case (mode)
                    2'b00: beg_c = rev_all[c*CH_W +: CH_W] ^ {CH_W{inv}};
                    2'b01: beg_c = END_I[c*CH_W +: CH_W] ^ {CH_W{inv}};
                    2'b10: beg_c = {CH_W{inv}};
                    2'b11: beg_c = pipe[c*CH_W +: CH_W] ^ {CH_W{inv}};
                    default: beg_c = rev_all[c*CH_W +: CH_W] ^ {CH_W{inv}};
                endcase
            end

            assign BEG_O[c*CH_W +: CH_W] = beg_c;
        end
    endgenerate

    assign Co0        = act[CFG_BITS-1];
    assign cfg_out    = shreg[CFG_BITS-1];
    assign cfg_err    = err_q;
    assign cfg_active = act;

endmodule

// File: tb/tb_term_loopback_matrix_cfg.sv
// Directed plus randomized bench for term_loopback_matrix_cfg against a
// bit-history reference model of the configuration chain and wire mapping.
module tb_term_loopback_matrix_cfg;
    localparam int NUM_CH   = 5;
    localparam int CH_W     = 16;
    localparam int CFG_BITS = 3*NUM_CH+1;
    localparam int W        = NUM_CH*CH_W;

    logic                UserCLK = 1'b0;
    logic                reset = 1'b0;
    logic [W-1:0]        END_I = '0;
    logic [W-1:0]        BEG_O;
    logic                Co0;
    logic                cfg_shift_en = 1'b0;
    logic                cfg_in = 1'b0;
    logic                cfg_commit = 1'b0;
    logic                cfg_out;
    logic                cfg_err;
    logic [CFG_BITS-1:0] cfg_active;

    term_loopback_matrix_cfg #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(8)) dut (
        .UserCLK(UserCLK), .reset(reset), .END_I(END_I), .BEG_O(BEG_O), .Co0(Co0),
        .cfg_shift_en(cfg_shift_en), .cfg_in(cfg_in), .cfg_commit(cfg_commit),
        .cfg_out(cfg_out), .cfg_err(cfg_err), .cfg_active(cfg_active)
    );

    always #5 UserCLK = ~UserCLK;

    int total  = 0;
    int passed = 0;

    // Reference state: committed config, error flag, END_I seen at last edge,
    // bits shifted since last commit, and last CFG_BITS bits since reset.
    logic [CFG_BITS-1:0] m_act = '0;
    logic                m_err = 1'b0;
    logic [W-1:0]        m_end_prev = '0;
    logic                win_q[$];
    logic                hist_q[$];

    function automatic logic [CH_W-1:0] bitrev(input logic [CH_W-1:0] x);
        logic [CH_W-1:0] r;
        for (int i = 0; i < CH_W; i++) r[i] = x[CH_W-1-i];
        return r;
    endfunction

    function automatic logic [W-1:0] model_beg();
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [CH_W-1:0] e, p, o;
            logic [1:0]      md;
            logic            iv;
            e  = END_I[c*CH_W +: CH_W];
            p  = m_end_prev[c*CH_W +: CH_W];
            md = m_act[3*c +: 2];
            iv = m_act[3*c + 2];
            if (md == 2'd2)      o = iv ? '1 : '0;
            else if (md == 2'd1) o = iv ? ~e : e;
            else if (md == 2'd0) o = iv ? ~bitrev(e) : bitrev(e);
            else                 o = iv ? ~bitrev(p) : bitrev(p);
            r[c*CH_W +: CH_W] = o;
        end
        return r;
    endfunction

    function automatic logic [CFG_BITS-1:0] fld(input int c, input logic [1:0] md, input logic iv);
        logic [CFG_BITS-1:0] v;
        v = '0;
        v[3*c +: 2] = md;
        v[3*c + 2]  = iv;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        logic exp_out;
        exp_out = (hist_q.size() == CFG_BITS) ? hist_q[0] : 1'b0;
        chk({tag, "_beg"}, BEG_O, model_beg());
        chk({tag, "_co0"}, W'(Co0), W'(m_act[CFG_BITS-1]));
        chk({tag, "_err"}, W'(cfg_err), W'(m_err));
        chk({tag, "_act"}, W'(cfg_active), W'(m_act));
        chk({tag, "_out"}, W'(cfg_out), W'(exp_out));
    endtask

    // One clock: drive controls, update the model at the edge, release controls.
    task automatic step(input logic sh, input logic d, input logic cm);
        cfg_shift_en = sh;
        cfg_in       = d;
        cfg_commit   = cm;
        @(posedge UserCLK);
        if (reset) begin
            m_act = '0;
            m_err = 1'b0;
            m_end_prev = '0;
            win_q.delete();
            hist_q.delete();
        end else begin
            m_end_prev = END_I;
            if (cm) begin
                if (win_q.size() == CFG_BITS) begin
                    for (int j = 0; j < CFG_BITS; j++) m_act[j] = win_q[CFG_BITS-1-j];
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                win_q.delete();
            end
            if (sh) begin
                win_q.push_back(d);
                hist_q.push_back(d);
                if (hist_q.size() > CFG_BITS) void'(hist_q.pop_front());
            end
        end
        #1;
        cfg_shift_en = 1'b0;
        cfg_commit   = 1'b0;
        cfg_in       = 1'b0;
    endtask

    // Shift the low nbits of v, MSB first; commit alone or on the last shift.
    task automatic load(input logic [CFG_BITS-1:0] v, input int nbits, input bit commit_on_last);
        for (int i = nbits-1; i >= 0; i--) step(1'b1, (i < CFG_BITS) ? v[i] : 1'b0, commit_on_last && (i == 0));
        if (!commit_on_last) step(1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [W-1:0] rand_w();
        return W'({$urandom(), $urandom(), $urandom()});
    endfunction

    logic [CFG_BITS-1:0] cfg2, cfg3, cfg4;

    initial begin
        // Reset
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        END_I = '0;
        END_I[15:0] = 16'h0001;
        #1;
        chk("reset_ch0", W'(BEG_O[15:0]), W'(16'h8000));
        chk("reset_co0", W'(Co0), '0);
        chk("reset_err", W'(cfg_err), '0);
        chk("reset_act", W'(cfg_active), '0);
        check_all("reset");

        // Channel 1 straight + invert
        cfg2 = fld(1, 2'b01, 1'b1);
        load(cfg2, CFG_BITS, 1'b0);
        END_I[16 +: 16] = 16'h00F3;
        #1;
        chk("ch1_straight_inv", W'(BEG_O[16 +: 16]), W'(16'hFF0C));
        chk("ch0_still_rev", W'(BEG_O[15:0]), W'(16'h8000));
        check_all("cfg2");

        // Short load is rejected, full load accepted
        cfg3 = fld(0, 2'b01, 1'b0) | fld(4, 2'b00, 1'b1);
        load(cfg3, CFG_BITS-1, 1'b0);
        chk("short_err", W'(cfg_err), W'(1'b1));
        chk("short_act_kept", W'(cfg_active), W'(cfg2));
        check_all("short");
        load(cfg3, CFG_BITS, 1'b0);
        chk("full_err", W'(cfg_err), '0);
        chk("full_act", W'(cfg_active), W'(cfg3));
        check_all("full");

        // Registered, tie and carry constant
        cfg4 = fld(2, 2'b11, 1'b0) | fld(3, 2'b10, 1'b1);
        cfg4[CFG_BITS-1] = 1'b1;
        load(cfg4, CFG_BITS, 1'b0);
        END_I[32 +: 16] = 16'h1234;
        step(1'b0, 1'b0, 1'b0);
        chk("ch2_registered", W'(BEG_O[32 +: 16]), W'(16'h2C48));
        chk("ch3_tie_one", W'(BEG_O[48 +: 16]), W'(16'hFFFF));
        chk("co0_one", W'(Co0), W'(1'b1));
        check_all("cfg4");
        END_I[32 +: 16] = 16'hA5F0;
        #1;
        check_all("ch2_latency_hold");
        step(1'b0, 1'b0, 1'b0);
        check_all("ch2_latency_next");

        // Last shift coincides with commit: rejected, next window starts at 1
        load(cfg3, CFG_BITS, 1'b1);
        chk("coincide_err", W'(cfg_err), W'(1'b1));
        chk("coincide_act_kept", W'(cfg_active), W'(cfg4));
        check_all("coincide");
        load(cfg2, CFG_BITS-1, 1'b0);
        chk("window_from_one_err", W'(cfg_err), '0);
        check_all("window_from_one");

        // Reset mid-shift after a non-default commit
        load(cfg4, CFG_BITS, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        END_I = '0;
        END_I[15:0] = 16'h0001;
        END_I[32 +: 16] = 16'h1234;
        #1;
        chk("midreset_act", W'(cfg_active), '0);
        chk("midreset_ch0", W'(BEG_O[15:0]), W'(16'h8000));
        chk("midreset_ch2", W'(BEG_O[32 +: 16]), W'(16'h2C48));
        chk("midreset_cfg_out", W'(cfg_out), '0);
        check_all("midreset");

        // Randomized configs and traffic
        for (int n = 0; n < 30; n++) begin
            int  nb;
            bit  col;
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(CFG_BITS-2, CFG_BITS+1) : CFG_BITS;
            col = ($urandom_range(0, 4) == 0);
            END_I = rand_w();
            load(CFG_BITS'({$urandom()}), nb, col);
            check_all("rnd_load");
            for (int k = 0; k < 3; k++) begin
                END_I = rand_w();
                #1;
                check_all("rnd_comb");
                step(1'b0, 1'b0, 1'b0);
                check_all("rnd_edge");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/term_loopback_matrix_cfg.md
Name: term_loopback_matrix_cfg

Overview:
- Parametrised, runtime-configurable successor to the fixed south/north termination switch matrix.
- Sits in edge termination tiles and returns incoming END wires to outgoing BEG wires for NUM_CH channel groups.
- Each channel has a selectable mode: reversed loopback, straight loopback, constant tie-off, or registered reversed loopback. Each channel also has an optional inversion.
- Configuration is loaded through a length-checked serial shift chain and applied atomically on commit.

Parameters:
- NUM_CH, 5, number of channel groups (single, double-mid, double-end, quad, quad-long).
- CH_W, 16, wires per channel; narrower physical groups are zero-padded at instantiation.
- CFG_BITS, 3*NUM_CH+1, configuration length (derived; not overridden).
- CNT_W, 8, width of the shift-length counter; must satisfy 2^CNT_W-1 >= CFG_BITS.

Ports:
- UserCLK  input  1  fabric user clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- END_I  input  NUM_CH*CH_W  incoming wire ends; channel c occupies [c*CH_W +: CH_W].
- BEG_O  output  NUM_CH*CH_W  outgoing wire begins, same packing.
- Co0  output  1  carry-chain termination value (configurable constant).
- cfg_shift_en  input  1  shift cfg_in into the chain this cycle.
- cfg_in  input  1  serial configuration data.
- cfg_commit  input  1  request transfer of the shift chain to the active config.
- cfg_out  output  1  serial chain output (MSB of shift register), for daisy-chaining.
- cfg_err  output  1  sticky: last commit rejected.
- cfg_active  output  CFG_BITS  active configuration readback.

Behaviour:
- State: shift register shreg[CFG_BITS], active config act[CFG_BITS], counter cnt[CNT_W], pipeline regs pipe[NUM_CH*CH_W], cfg_err flag.
- Reset, synchronous, takes priority over all other inputs and may occur mid-shift. It clears shreg, act, cnt, pipe and cfg_err to 0. After reset all channels are in mode 00, non-inverted, and Co0=0, which reproduces the legacy fixed reversed loopback.
- Config fields per channel c:
  - act[3c+1:3c] = mode: 00 reversed pass, 01 straight pass, 10 tie, 11 registered reversed.
  - act[3c+2] = INV. In modes 00/01/11 it inverts every output bit of the channel. In mode 10 it is the tie value driven on all bits.
  - act[CFG_BITS-1] = Co0 value.
- Reversed mapping: rev_c[i] = END_I[c*CH_W + CH_W-1-i].
- Straight mapping: BEG bit i = END bit i.
- Modes 00, 01 and 10 are combinational with zero latency.
- Mode 11: pipe_c <= rev_c every cycle regardless of mode, so there is no stale data on mode switch. BEG_O_c = pipe_c ^ {CH_W{INV}}, giving 1-cycle latency.
- Shift: when cfg_shift_en=1, shreg <= {shreg[CFG_BITS-2:0], cfg_in}, so the first bit shifted in ends up at the MSB (Co0 field). cfg_out = shreg[CFG_BITS-1].
- cnt increments on each shift and saturates at all-ones.
- Commit, when cfg_commit=1:
  - If cnt == CFG_BITS: act <= shreg (pre-shift value) and cfg_err <= 0.
  - Otherwise: act is unchanged and cfg_err <= 1.
  - In both cases cnt <= (cfg_shift_en ? 1 : 0).
- Simultaneous shift+commit: the commit uses the old shreg and old cnt; the shift is counted in the new window.
- New act takes effect on outputs the cycle after the commit edge (combinational modes). For mode 11 the registered value is already current, so outputs change on the same post-commit cycle.
- cfg_active = act. Co0 = act[CFG_BITS-1].
- No X-propagation from unused padded bits: padded END_I inputs are tied 0 by the integrator.

Test Plan:
- Reset then END_I ch0 = 0x0001 -> BEG_O ch0 = 0x8000 combinationally; Co0=0; cfg_err=0; cfg_active=0.
- Shift 16 bits (NUM_CH=5) with ch1 mode=01, INV=1, then commit; END_I ch1=0x00F3 -> BEG_O ch1=0xFF0C next cycle; other channels still reversed; cfg_err=0.
- Shift only 15 bits then commit -> cfg_err=1, cfg_active unchanged. Shift 16 bits then commit -> cfg_err=0 and config applied.
- Ch2 mode=11: drive END_I ch2=0x1234 at cycle N -> BEG_O ch2=0x2C48 from cycle N+1. Ch3 mode=10, INV=1 -> 0xFFFF. Co0 bit=1 -> Co0=1.
- Shift 16 bits with the 16th shift asserted in the same cycle as commit -> commit rejected (cnt=15), cfg_err=1, cnt=1 afterwards.
- Assert reset after 8 of 16 shifts with a prior committed non-default config -> next cycle act=0, shreg=0, cnt=0, pipe=0, outputs revert to reversed loopback.
